iter_div32: RTL and testbench

//  32-bit multi-cycle integer divider for the CPU EXE stage (DIV/MOD, signed and unsigned).

---
 rtl/iter_div32.sv | 151 +++++++++++++++
 tb/tb_iter_div32.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/iter_div32.sv
// ---------------------------------------------------------------------------
// iter_div32 : 32-bit multi-cycle integer divider (DIV/MOD, signed/unsigned)
//
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// clock. The caller raises div with stable operands and holds it until the
// one-cycle complete pulse. Dropping div before completion aborts quietly.
//
// Ports
//   div_clk     in   1   clock, rising edge
//   resetn      in   1   synchronous active-low reset
//   div         in   1   request, held high for the whole operation
//   div_signed  in   1   1: two's-complement operands/results, 0: unsigned
//   x           in   32  dividend
//   y           in   32  divisor
//   s           out  32  quotient  (valid while complete=1, held afterwards)
//   r           out  32  remainder (valid while complete=1, held afterwards)
//   complete    out  1   one-cycle done pulse
//
// Sequence: IDLE -(div)-> LOAD -> RUN x32 -> DONE -> IDLE
// Latency : div seen at edge N -> complete during the cycle after edge N+33.
// ---------------------------------------------------------------------------
module iter_div32 (
  input  logic        div_clk,
  input  logic        resetn,
  input  logic        div,
  input  logic        div_signed,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] s,
  output logic [31:0] r,
  output logic        complete
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [5:0]        cnt;
  logic [DATA_W-1:0] xsh;    // dividend magnitude, shifted out MSB first
  logic [DATA_W-1:0] yabs;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic              qneg;
  logic              rneg;
  logic              yzero;

  logic [DATA_W:0]   trial;
  logic              ge;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic              last_step;

  // Magnitude of a possibly-signed operand.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                            input logic              sgn);
    return (sgn & v[DATA_W-1]) ? (~v + 32'd1) : v;
  endfunction

  // Conditional two's-complement negation used for the final sign fix.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic              n);
    return n ? (~v + 32'd1) : v;
  endfunction

  // FSM state register
  always_ff @(posedge div_clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next state and outputs
  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    case (state)
      IDLE: if (div) state_nxt = LOAD;
      LOAD: state_nxt = div ? RUN : IDLE;
      RUN: begin
        if (!div)            state_nxt = IDLE;
        else if (last_step)  state_nxt = DONE;
      end
      DONE: begin
        complete  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // Only the low 32 bits of the difference are kept; when the subtraction is
  // taken the true result always fits, so the truncated 32-bit difference is
  // exact.
  always_comb begin
    trial     = {rem, xsh[DATA_W-1]};
    ge        = (trial >= {1'b0, yabs});
    rem_nxt   = ge ? (trial[DATA_W-1:0] - yabs) : trial[DATA_W-1:0];
    quo_nxt   = {quo[DATA_W-2:0], ge};
    last_step = (cnt == 6'd31);
  end

  // Operand capture and iteration datapath (no reset needed: always
  // initialised in LOAD before use)
  always_ff @(posedge div_clk) begin
    case (state)
      LOAD: begin
        xsh   <= mag(x, div_signed);
        yabs  <= mag(y, div_signed);
        rem   <= '0;
        quo   <= '0;
        qneg  <= div_signed & (x[DATA_W-1] ^ y[DATA_W-1]);
        rneg  <= div_signed & x[DATA_W-1];
        yzero <= (y == '0);
      end
      RUN: begin
        xsh <= {xsh[DATA_W-2:0], 1'b0};
        rem <= rem_nxt;
        quo <= quo_nxt;
      end
      default: ;
    endcase
  end

  // Step counter and registered results. Results are written on the final
  // RUN edge so they are already stable during DONE. With y==0 the restoring
  // loop leaves rem=|x|, so the remainder sign fix alone yields r=x; only the
  // quotient needs forcing to all-ones.
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      cnt <= '0;
      s   <= '0;
      r   <= '0;
    end else begin
      if (state == LOAD)     cnt <= '0;
      else if (state == RUN) cnt <= cnt + 6'd1;

      if (state == RUN && last_step && div) begin
        s <= yzero ? {DATA_W{1'b1}} : neg_if(quo_nxt, qneg);
        r <= neg_if(rem_nxt, rneg);
      end
    end
  end

endmodule

// File: tb/tb_iter_div32.sv
// ---------------------------------------------------------------------------
// tb_iter_div32 : self-checking bench for iter_div32.
// Directed corner cases, reset/abort behaviour and randomized operations
// compared against a plain-arithmetic division model.
// ---------------------------------------------------------------------------
module tb_iter_div32;

  logic        div_clk = 1'b0;
  logic        resetn;
  logic        div;
  logic        div_signed;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] s;
  logic [31:0] r;
  logic        complete;

  int n_vec = 0;
  int n_err = 0;

  always #5 div_clk = ~div_clk;

  iter_div32 dut (
    .div_clk    (div_clk),
    .resetn     (resetn),
    .div        (div),
    .div_signed (div_signed),
    .x          (x),
    .y          (y),
    .s          (s),
    .r          (r),
    .complete   (complete)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: language-level / and % (truncating, remainder follows x).
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic sg,
                                  output logic [31:0] qs, output logic [31:0] rs);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     tq, tr;
    if (b == 32'd0) begin
      qs = 32'hFFFF_FFFF;
      rs = a;
    end else if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
      tq = sa / sb;
      tr = sa % sb;
      qs = tq[31:0];
      rs = tr[31:0];
    end else begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      tq = ua / ub;
      tr = ua % ub;
      qs = tq[31:0];
      rs = tr[31:0];
    end
  endfunction

  // One complete operation; optionally disturbs operands mid-run.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic [31:0] es,
                        input logic [31:0] er, input bit scramble);
    int cyc;
    bit seen;
    @(negedge div_clk);
    div = 1'b1; x = a; y = b; div_signed = sg;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 50) begin
      @(posedge div_clk); #1;
      cyc++;
      if (complete) seen = 1;
      else if (scramble && cyc == 4) begin
        x = $urandom;
        y = $urandom;
        div_signed = 1'($urandom);
      end
    end
    div = 1'b0;
    chk("complete_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency_le_34", 32'(cyc <= 34), 32'd1);
      chk("quotient", s, es);
      chk("remainder", r, er);
      @(posedge div_clk); #1;
      chk("single_pulse", 32'(complete), 32'd0);
      chk("quotient_hold", s, es);
    end
  endtask

  task automatic run_ref(input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input bit scramble);
    logic [31:0] es, er;
    ref_div(a, b, sg, es, er);
    run_op(a, b, sg, es, er, scramble);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          pulses;
    logic [31:0] ra, rb;
    logic        rsg;

    resetn = 1'b0; div = 1'b0; div_signed = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge div_clk);
    #1;
    chk("reset_s", s, 32'd0);
    chk("reset_r", r, 32'd0);
    chk("reset_complete", 32'(complete), 32'd0);
    @(negedge div_clk);
    resetn = 1'b1;

    // Directed cases with hand-derived results
    run_op(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          0);
    run_op(32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  0);
    run_op(32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          0);
    run_op(32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          0);
    run_op(32'hFFFF_FFFF,  32'd1,          1'b1, 32'hFFFF_FFFF,  32'd0,          0);
    run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          0);
    run_op(32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234,  0);
    run_op(32'h0000_1234,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h0000_1234,  0);
    run_op(32'h8000_0005,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h8000_0005,  0);
    run_op(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1);

    // Abort by dropping div mid-run: no pulse may follow
    @(negedge div_clk);
    div = 1'b1; x = 32'd1000; y = 32'd3; div_signed = 1'b0;
    repeat (6) @(posedge div_clk);
    @(negedge div_clk);
    div = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge div_clk); #1;
      if (complete) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);

    // Reset mid-run, then restart
    @(negedge div_clk);
    div = 1'b1; x = 32'hDEAD_BEEF; y = 32'd13; div_signed = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(posedge div_clk); #1;
      if (complete) pulses++;
    end
    @(negedge div_clk);
    resetn = 1'b0; div = 1'b0;
    @(posedge div_clk); #1;
    if (complete) pulses++;
    chk("midrun_reset_s", s, 32'd0);
    chk("midrun_reset_r", r, 32'd0);
    @(negedge div_clk);
    resetn = 1'b1;
    repeat (40) begin
      @(posedge div_clk); #1;
      if (complete) pulses++;
    end
    chk("reset_no_pulse", 32'(pulses), 32'd0);
    run_ref(32'hDEAD_BEEF, 32'd13, 1'b0, 0);

    // Randomized operations
    for (int i = 0; i < 1000; i++) begin
      ra  = (($urandom & 32'h7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'($urandom) >> $urandom_range(0, 31);
        default: rb = 32'($urandom);
      endcase
      rsg = 1'($urandom);
      run_ref(ra, rb, rsg, 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge div_clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
